// File: rtl/product_bcd_conv_pkg.sv
// Shared types and constants for the multiplier-product BCD conversion path.
// The display stage imports the same widths so both ends agree on the product format.
package product_bcd_pkg;

    localparam int PROD_WIDTH = 8;
    localparam int BCD_DIGITS = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        FINISH  = 2'd2
    } state_t;

endpackage

// File: rtl/product_bcd_conv_if.sv
// Start/busy/done handshake plus data between the control logic (master)
// and the binary-to-BCD converter (slave).
interface product_bcd_conv_if
    import product_bcd_pkg::*;
#(
    parameter int WIDTH  = PROD_WIDTH,
    parameter int DIGITS = BCD_DIGITS
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;

    modport master (output start, bin, input busy, done, bcd);
    modport slave  (input start, bin, output busy, done, bcd);
endinterface

// File: rtl/product_bcd_conv_bcd_add3.sv
// Single-digit double-dabble correction: a digit of 5..9 becomes 8..12 so the
// following left shift carries into the next decimal digit.
module bcd_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);
    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
endmodule

// File: rtl/product_bcd_conv.sv
// Sequential shift-and-add-3 converter: one product bit per clock, result
// published on bcd together with a single-cycle done pulse.
module product_bcd_conv
    import product_bcd_pkg::*;
#(
    parameter int WIDTH  = PROD_WIDTH,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic               clk,
    input  logic               rst_n,
    product_bcd_conv_if.slave  bus
);
    localparam int SW = 4*DIGITS + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    state_t                state_q, state_d;
    logic [SW-1:0]         scratch_q, scratch_d;
    logic [SW-1:0]         corrected;
    logic [CW-1:0]         count_q, count_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  done_q, done_d;

    // Binary field passes straight through; each BCD digit gets its own corrector.
    assign corrected[WIDTH-1:0] = scratch_q[WIDTH-1:0];

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_add3 u_add3 (
            .digit_i (scratch_q[WIDTH + 4*i +: 4]),
            .digit_o (corrected[WIDTH + 4*i +: 4])
        );
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d   = state_q;
        scratch_d = scratch_q;
        count_d   = count_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    scratch_d = {{(4*DIGITS){1'b0}}, bus.bin};
                    count_d   = CW'(WIDTH);
                    state_d   = CONVERT;
                end
            end
            CONVERT: begin
                scratch_d = corrected << 1;
                count_d   = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                bcd_d   = scratch_q[SW-1 -: 4*DIGITS];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            scratch_q <= '0;
            count_q   <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            count_q   <= count_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_product_bcd_conv.sv
// Directed bench for the product BCD converter: handshake timing, range
// corners, full sweep against a decimal model, start/bin/reset robustness.
module tb_product_bcd_conv;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    product_bcd_conv_if bus ();

    product_bcd_conv dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Called at the negedge just after the accepting edge (index 0); index i is
    // the negedge after edge k+i. Gives up after 20 cycles with done_at = -1.
    task automatic wait_done(output int done_at, output int busy_cnt);
        done_at  = -1;
        busy_cnt = 0;
        for (int i = 0; i < 20 && done_at < 0; i++) begin
            if (i > 0) @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) done_at = i;
        end
    endtask

    task automatic convert(input string tag, input logic [7:0] v, input logic [11:0] exp);
        int done_at;
        int busy_cnt;
        @(negedge clk);
        bus.bin   = v;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(done_at, busy_cnt);
        check({tag, "_latency"}, done_at, 9);
        check({tag, "_busy_cycles"}, busy_cnt, 9);
        check({tag, "_bcd"}, bus.bcd, exp);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, bus.done, 1'b0);
    endtask

    initial begin
        int done_at;
        int busy_cnt;
        int n_done;
        int busy_after;
        int t;
        int done_t[3];
        logic [7:0] b2b_bin[3];
        logic [11:0] b2b_exp[3];

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.bin   = '0;
        #1;
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_bcd", bus.bcd, 12'h000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Range corners
        convert("max_product", 8'd225, 12'h225);
        convert("zero", 8'd0, 12'h000);
        convert("full_255", 8'd255, 12'h255);
        convert("val_99", 8'd99, 12'h099);
        convert("val_100", 8'd100, 12'h100);

        for (int v = 0; v < 256; v++) begin
            convert($sformatf("sweep_%0d", v), 8'(v), to_bcd(v));
        end

        // Start re-pulsed while busy must be dropped, not queued
        @(negedge clk);
        bus.bin   = 8'd42;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 8'd77;
        @(negedge clk);
        bus.start  = 1'b0;
        n_done     = 0;
        busy_after = 0;
        done_at    = -1;
        for (int i = 4; i < 30; i++) begin
            if (i > 4) @(negedge clk);
            if (bus.done) begin
                n_done++;
                if (done_at < 0) done_at = i;
            end else if (done_at >= 0 && bus.busy) begin
                busy_after++;
            end
        end
        check("busy_start_done_count", n_done, 1);
        check("busy_start_latency", done_at, 9);
        check("busy_start_no_second", busy_after, 0);
        check("busy_start_bcd", bus.bcd, 12'h042);

        // bin changes right after acceptance
        @(negedge clk);
        bus.bin   = 8'd200;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.bin   = 8'd13;
        wait_done(done_at, busy_cnt);
        check("stable_latency", done_at, 9);
        check("stable_bcd", bus.bcd, 12'h200);

        // Reset mid-conversion
        @(negedge clk);
        bus.bin   = 8'd144;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", bus.busy, 1'b0);
        check("midreset_done", bus.done, 1'b0);
        check("midreset_bcd", bus.bcd, 12'h000);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        busy_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done) n_done++;
            if (bus.busy) busy_cnt++;
        end
        check("midreset_no_done", n_done, 0);
        check("midreset_stays_idle", busy_cnt, 0);
        convert("after_reset", 8'd144, 12'h144);

        // Back-to-back with start held high
        b2b_bin = '{8'd6, 8'd36, 8'd81};
        b2b_exp = '{12'h006, 12'h036, 12'h081};
        @(negedge clk);
        bus.bin   = b2b_bin[0];
        bus.start = 1'b1;
        n_done    = 0;
        for (t = 0; t < 60 && n_done < 3; t++) begin
            @(negedge clk);
            if (bus.done) begin
                done_t[n_done] = t;
                check($sformatf("b2b_bcd_%0d", n_done), bus.bcd, b2b_exp[n_done]);
                n_done++;
                if (n_done < 3) bus.bin = b2b_bin[n_done];
                else            bus.start = 1'b0;
            end
        end
        check("b2b_done_count", n_done, 3);
        if (n_done == 3) begin
            check("b2b_spacing_1", done_t[1] - done_t[0], 10);
            check("b2b_spacing_2", done_t[2] - done_t[1], 10);
        end
        busy_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
        end
        check("b2b_stops_after_release", busy_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/product_bcd_conv.md
# product_bcd_conv

Sequential binary-to-BCD converter that sits directly downstream of the 4×4 array multiplier and turns its 8-bit product into three BCD digits for the seven-segment display stage. It uses the shift-and-add-3 (double-dabble) algorithm, one bit per clock. A start/busy/done handshake lets the control logic request a conversion whenever the multiplier operands change.

## Interface
Parameters:
- WIDTH, 8, binary input width; it matches the multiplier product `p`.
- DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH − 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset. **Asynchronous, active-low.**
- start  in  1  conversion request; sampled only in IDLE.
- bin  in  WIDTH  binary value (multiplier product); captured on the accepted start.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when `bcd` has just been updated.
- bcd  out  4·DIGITS  result; digit i is at bits [4i+3:4i], digit 0 is the ones digit.

## Operation
- The FSM has three states: IDLE, CONVERT and FINISH.
- **IDLE.** When `start`=1, the block:
  - loads the shift register with `{DIGITS*4'b0, bin}`;
  - loads the bit counter with WIDTH;
  - moves to CONVERT.
  - When `start`=0, it stays in IDLE.
- **CONVERT.** Each cycle, the block:
  - adds 3 to every BCD digit of the scratch register that is ≥5;
  - then shifts the whole register left by 1;
  - decrements the counter.
  - After the shift in which the counter reaches 0, it moves to FINISH.
- **FINISH.** The block copies the scratch BCD field to `bcd`, pulses `done`, and returns to IDLE.
- `start` is ignored in CONVERT and FINISH, with no queueing. The control logic must wait for `done` before issuing a new request.
- `bin` is only sampled on the accepted start. Later changes to `bin` do not affect the conversion in flight.
- `bcd` holds its last result until the next FINISH. It is never partially updated.
- Digits greater than 9 never appear on `bcd` for any legal parameterisation.
- Width rules:
  - scratch register is 4·DIGITS+WIDTH bits;
  - counter is clog2(WIDTH+1) bits;
  - the add-3 correction is computed on a 4-bit digit with no carry-out into the neighbouring digit; the corrected value is ≤12.

## Timing
- **Reset values:** state=IDLE, `busy`=0, `done`=0, `bcd`=0, scratch=0, counter=0.
- **Reset mid-conversion:** the conversion is aborted immediately. No `done` is produced, and `bcd` returns to 0.
- **Latency:** if `start` is accepted at edge k, then:
  - `busy` is 1 from after edge k until after edge k+WIDTH+1;
  - `done`=1 and the new `bcd` are visible after edge k+WIDTH+1, for exactly one cycle;
  - for WIDTH=8, that is 9 cycles from the start edge to `done`.
- `busy` is 1 in CONVERT and FINISH.
- `done` is registered and asserted only in the cycle after FINISH is entered. It never coincides with `busy`=0 → 1.
- **Back-to-back:** `start` held high continuously gives one conversion every WIDTH+2 cycles. It is re-accepted on the first IDLE cycle after `done`.

## Structure
- **Package `product_bcd_pkg`:** holds the state enum (IDLE, CONVERT, FINISH) and the constants `PROD_WIDTH`=8 and `BCD_DIGITS`=3, shared with the display stage.
- **Sub-module `bcd_add3`:** a combinational 4-bit digit corrector (out = in ≥ 5 ? in+3 : in). It is instantiated DIGITS times via generate.

## Test plan
- **Maximum multiplier product:** reset, then `bin`=225 (15×15) with a 1-cycle `start` → `bcd`=12'h225 and `done` high exactly 9 cycles after the start edge; `busy` high for those 9 cycles.
- **Zero and full range:** `bin`=0 → 12'h000; `bin`=255 → 12'h255; `bin`=99 → 12'h099; `bin`=100 → 12'h100. Then sweep all 256 values against a reference model.
- **Start while busy:** `start` re-pulsed at cycle 3 of a conversion of 42 with `bin`=77 → a single `done`, `bcd`=12'h042, and no second conversion.
- **Input stability:** `bin` changed from 200 to 13 during CONVERT → `bcd`=12'h200.
- **Reset mid-conversion:** `rst_n` low at cycle 4 of a conversion of 144 → `busy`=0, `done` never asserted, `bcd`=0. After release, a fresh conversion of 144 → 12'h144.
- **Back-to-back:** `start` held high with `bin` stepping 6, 36, 81 at each `done` → results 12'h006, 12'h036, 12'h081, with `done` pulses 10 cycles apart.
